// File: rtl/flag_register_unit_if.sv
// ----------------------------------------------------------------------------
// flag_register_unit_if
//   Bundles the EX-stage inputs and the flag outputs of flag_register_unit.
//   master : the pipeline side. It drives the EX-stage instruction and
//            observes the flags.
//   slave  : flag_register_unit. It consumes the EX stage and drives the flags.
// Signals
//   ex_valid   EX holds a real (non-bubble) instruction
//   stall      EX instruction held, must not commit
//   flush      EX instruction squashed
//   opcode     4-bit EX opcode
//   op_a/op_b  ALU operands (pre-saturation)
//   alu_result final (saturated) ALU result
//   flag_reg   committed {N,Z,V}
//   flag_fwd   {N,Z,V} as they will be after this cycle's commit
//   flag_wr    registered pulse, one cycle after a commit with a non-zero mask
// ----------------------------------------------------------------------------
interface flag_register_unit_if #(
    parameter int DATA_W = 16
);
    logic              ex_valid;
    logic              stall;
    logic              flush;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [2:0]        flag_reg;
    logic [2:0]        flag_fwd;
    logic              flag_wr;

    modport master (
        output ex_valid, stall, flush, opcode, op_a, op_b, alu_result,
        input  flag_reg, flag_fwd, flag_wr
    );

    modport slave (
        input  ex_valid, stall, flush, opcode, op_a, op_b, alu_result,
        output flag_reg, flag_fwd, flag_wr
    );
endinterface

// File: rtl/flag_register_unit.sv
// ----------------------------------------------------------------------------
// flag_register_unit
//   EX-stage producer of the {N,Z,V} condition flags for the branch unit.
//   It derives N/Z/V from the ALU result and operands. It then commits them
//   selectively through a per-opcode mask, and honours stall and flush.
//   A combinational forward (flag_fwd) exposes the post-commit flags in the
//   same cycle.
// Ports
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset, dominates all other inputs
//   bus    flag_register_unit_if.slave (EX inputs, flag outputs)
// ----------------------------------------------------------------------------
module flag_register_unit #(
    parameter int DATA_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    flag_register_unit_if.slave   bus
);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111
    } opcode_e;

    // The flag triple is always ordered {N,Z,V}.
    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    flags_t            r_flag;
    logic              r_wr;

    flags_t            w_mask;
    flags_t            w_new;
    flags_t            w_merged;
    logic              w_commit;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_v_add;
    logic              w_v_sub;

    assign w_commit = bus.ex_valid & ~bus.stall & ~bus.flush;

    // Update mask. Opcodes with bit 3 set (mem/ctrl) fall into the default.
    always_comb begin
        w_mask = '0;
        case (bus.opcode)
            OP_ADD, OP_SUB:                 w_mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_mask = 3'b010;
            default:                        w_mask = 3'b000;
        endcase
    end

    // Overflow is taken from the unsaturated operation, because the result
    // port has already been clamped upstream.
    assign w_sum   = bus.op_a + bus.op_b;
    assign w_diff  = bus.op_a - bus.op_b;
    assign w_v_add = (bus.op_a[MSB] == bus.op_b[MSB]) && (w_sum[MSB]  != bus.op_a[MSB]);
    assign w_v_sub = (bus.op_a[MSB] != bus.op_b[MSB]) && (w_diff[MSB] != bus.op_a[MSB]);

    // N uses the saturated result, so it carries the true sign on overflow.
    assign w_new.n = bus.alu_result[MSB];
    assign w_new.z = (bus.alu_result == '0);
    assign w_new.v = (bus.opcode == OP_SUB) ? w_v_sub : w_v_add;

    assign w_merged = (w_new & w_mask) | (r_flag & ~w_mask);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flag <= '0;
            r_wr   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_flag <= w_merged;
            end
            r_wr <= w_commit && (w_mask != 3'b000);
        end
    end

    assign bus.flag_reg = r_flag;
    assign bus.flag_wr  = r_wr;
    // Zero-cycle path. It depends only on the current commit, not on flag_wr.
    assign bus.flag_fwd = w_commit ? w_merged : r_flag;
endmodule

// File: tb/tb_flag_register_unit.sv
// ----------------------------------------------------------------------------
// tb_flag_register_unit
//   Directed vectors with hand-computed {N,Z,V} expectations for
//   flag_register_unit. Inputs change 1 ns after a rising edge. The
//   combinational forward is sampled 1 ns after that, and the registered
//   outputs are sampled 1 ns after the next edge.
// ----------------------------------------------------------------------------
module tb_flag_register_unit;
    localparam int DATA_W = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    flag_register_unit_if #(.DATA_W(DATA_W)) bus ();

    flag_register_unit #(.DATA_W(DATA_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic st, input logic fl, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
        bus.ex_valid   = v;
        bus.stall      = st;
        bus.flush      = fl;
        bus.opcode     = op;
        bus.op_a       = a;
        bus.op_b       = b;
        bus.alu_result = r;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic chk_regs(input string tag, input logic [2:0] f, input logic w);
        chk({tag, ".reg"}, {13'd0, bus.flag_reg}, {13'd0, f});
        chk({tag, ".wr"},  {15'd0, bus.flag_wr},  {15'd0, w});
    endtask

    task automatic chk_fwd(input string tag, input logic [2:0] f);
        #1;
        chk({tag, ".fwd"}, {13'd0, bus.flag_fwd}, {13'd0, f});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        step();
        chk_regs("reset", 3'b000, 1'b0);
        chk_fwd("reset", 3'b000);

        // Positive overflow: the saturated result keeps N=0, and V is set.
        drv(1'b1, 1'b0, 1'b0, 4'b0000, 16'h7FFF, 16'h0001, 16'h7FFF);
        chk_fwd("add_povf", 3'b001);
        step();
        chk_regs("add_povf", 3'b001, 1'b1);
        idle();
        chk_fwd("idle_after_add", 3'b001);
        step();
        chk_regs("idle_after_add", 3'b001, 1'b0);

        // SUB to zero, then XOR back-to-back. Only Z is rewritten.
        drv(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0005, 16'h0005, 16'h0000);
        chk_fwd("sub_zero", 3'b010);
        step();
        chk_regs("sub_zero", 3'b010, 1'b1);
        drv(1'b1, 1'b0, 1'b0, 4'b0010, 16'h1234, 16'h9234, 16'h8000);
        chk_fwd("xor_neg", 3'b000);
        step();
        chk_regs("xor_neg", 3'b000, 1'b1);

        // Negative overflow: 0x8000 + 0xFFFF gives sum 0x7FFF and saturates to 0x8000.
        drv(1'b1, 1'b0, 1'b0, 4'b0000, 16'h8000, 16'hFFFF, 16'h8000);
        step();
        chk_regs("add_novf", 3'b101, 1'b1);
        drv(1'b1, 1'b0, 1'b0, 4'b0100, 16'h0000, 16'h0001, 16'h0000);
        step();
        chk_regs("sll_zero", 3'b111, 1'b1);
        drv(1'b1, 1'b0, 1'b0, 4'b0110, 16'h0001, 16'h0001, 16'h8000);
        step();
        chk_regs("ror_nz", 3'b101, 1'b1);

        // Opcodes with a zero mask commit but change nothing.
        drv(1'b1, 1'b0, 1'b0, 4'b0111, 16'h0000, 16'h0000, 16'h0000);
        chk_fwd("paddsb", 3'b101);
        step();
        chk_regs("paddsb", 3'b101, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 4'b0011, 16'h0000, 16'h0000, 16'h0000);
        step();
        chk_regs("red", 3'b101, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 4'b1001, 16'h0000, 16'h0000, 16'h0000);
        step();
        chk_regs("memop", 3'b101, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 4'b0001, 16'h0005, 16'h0005, 16'h0000);
        chk_fwd("bubble", 3'b101);
        step();
        chk_regs("bubble", 3'b101, 1'b0);

        // A stalled SUB holds for 3 cycles, then commits exactly once.
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 1'b0, 4'b0001, 16'h0005, 16'h0005, 16'h0000);
            chk_fwd("stall", 3'b101);
            step();
            chk_regs("stall", 3'b101, 1'b0);
        end
        drv(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0005, 16'h0005, 16'h0000);
        chk_fwd("unstall", 3'b010);
        step();
        chk_regs("unstall", 3'b010, 1'b1);
        idle();
        step();
        chk_regs("after_unstall", 3'b010, 1'b0);

        // Flush suppresses the commit, with or without stall.
        drv(1'b1, 1'b0, 1'b1, 4'b0000, 16'h7FFF, 16'h0001, 16'h7FFF);
        chk_fwd("flush", 3'b010);
        step();
        chk_regs("flush", 3'b010, 1'b0);
        drv(1'b1, 1'b1, 1'b1, 4'b0000, 16'h7FFF, 16'h0001, 16'h7FFF);
        chk_fwd("stall_flush", 3'b010);
        step();
        chk_regs("stall_flush", 3'b010, 1'b0);

        // Reset during a stalled ADD. Reset must also win over the commit
        // when stall drops in the same cycle that reset is asserted.
        drv(1'b1, 1'b1, 1'b0, 4'b0000, 16'h7FFF, 16'h0001, 16'h7FFF);
        step();
        chk_regs("rst_stall_hold", 3'b010, 1'b0);
        rst = 1'b1;
        step();
        drv(1'b1, 1'b0, 1'b0, 4'b0000, 16'h7FFF, 16'h0001, 16'h7FFF);
        step();
        chk_regs("rst_dominates", 3'b000, 1'b0);
        rst = 1'b0;
        idle();
        step();
        chk_regs("rst_release", 3'b000, 1'b0);
        chk_fwd("rst_release", 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
